// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: PC owner, ROM address driver and 2-entry fetch buffer
// feeding decode over a valid/ready handshake. Execute redirects flush the
// buffer and restart fetch at the target.
// Optional build macro: FETCH_FAULT_EN adds a PC alignment/ROM bound check
// that stops fetch in a FAULT state until the next redirect or reset.
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ROM_WORDS = 62,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic        fetch_fault
);

    typedef enum logic {ST_RUN = 1'b0, ST_FAULT = 1'b1} state_t;

    // The buffer logic below is written for exactly two entries.
    if (BUF_DEPTH != 2 || ROM_WORDS < 1) begin : g_param_check
        $error("instr_fetch_stage: BUF_DEPTH must be 2 and ROM_WORDS >= 1");
    end

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [1:0]  r_count;
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [31:0] r_buf_instr [2];
    logic [31:0] r_buf_pc    [2];

    logic        w_out_valid;
    logic        w_pop;
    logic        w_push;
    logic        w_pc_ok;
    logic [31:0] w_redirect_target;

`ifdef FETCH_FAULT_EN
    // Fetch only from aligned addresses that index a populated ROM word.
    assign w_pc_ok           = (r_pc[1:0] == 2'b00) &&
                               ({2'b00, r_pc[31:2]} < 32'(ROM_WORDS));
    // The target is taken as-is so a misaligned redirect can be reported.
    assign w_redirect_target = redirect_pc;
    assign fetch_fault       = (r_state == ST_FAULT);
`else
    assign w_pc_ok           = 1'b1;
    assign w_redirect_target = {redirect_pc[31:2], 2'b00};
    assign fetch_fault       = 1'b0;
`endif

    assign w_out_valid = (r_count != 2'd0);
    // A redirect squashes whatever decode accepts in the same cycle.
    assign w_pop       = w_out_valid && out_ready && !redirect_valid;
    assign w_push      = (r_state == ST_RUN) && !redirect_valid && w_pc_ok &&
                         ((r_count < 2'd2) || w_pop);

    // Next-state logic: redirect always returns to RUN; a bad PC stops fetch.
    always_comb begin
        w_state_next = r_state;
        if (redirect_valid) begin
            w_state_next = ST_RUN;
        end else if (r_state == ST_RUN && !w_pc_ok) begin
            w_state_next = ST_FAULT;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // PC, occupancy and pointers; redirect overrides push and pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc     <= RESET_PC;
            r_count  <= 2'd0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
        end else if (redirect_valid) begin
            r_pc     <= w_redirect_target;
            r_count  <= 2'd0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
        end else begin
            if (w_push) begin
                r_pc     <= r_pc + 32'd4;
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 2'd1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 2'd1;
            end
        end
    end

    // One storage slot per buffer entry, written when it is the push target.
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        // Capture the ROM word and its PC on push into this slot.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_buf_instr[gi] <= 32'd0;
                r_buf_pc[gi]    <= 32'd0;
            end else if (w_push && (r_wr_ptr == 1'(gi))) begin
                r_buf_instr[gi] <= rom_data;
                r_buf_pc[gi]    <= r_pc;
            end
        end
    end

    assign rom_addr     = r_pc;
    assign out_valid    = w_out_valid;
    // Head fields read as zero whenever the buffer is empty.
    assign out_instr    = w_out_valid ? r_buf_instr[r_rd_ptr] : 32'd0;
    assign out_pc       = w_out_valid ? r_buf_pc[r_rd_ptr]    : 32'd0;
    assign out_pc_plus4 = w_out_valid ? (r_buf_pc[r_rd_ptr] + 32'd4) : 32'd0;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: a per-cycle vector table covering
// streaming, stalls, redirects and PC wrap, plus hand sequences for
// asynchronous reset mid-stream and (when FETCH_FAULT_EN is defined) faults.
module tb_instr_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        fetch_fault;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // ROM contents: a recognisable word derived from the word index.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {8'h13, a[25:2]} ^ 32'h0055_AA00;
    endfunction

    assign rom_data = rom_word(rom_addr);

    instr_fetch_stage dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4),
        .fetch_fault    (fetch_fault)
    );

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_addr;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rpc,
                                input logic ev, input logic [31:0] epc, input logic [31:0] eaddr);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.e_valid = ev; v.e_pc = epc; v.e_addr = eaddr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observe the current head against an expected valid PC.
    task automatic chk_head(input string tag, input logic [31:0] epc);
        chk({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, " out_pc"}, out_pc, epc);
        chk({tag, " out_instr"}, out_instr, rom_word(epc));
        chk({tag, " out_pc_plus4"}, out_pc_plus4, epc + 32'd4);
    endtask

    int n_main;

    initial begin
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        out_ready      = 1'b0;

        // Columns: ready, redirect, target | expected valid, head pc, rom_addr
        tbl[0]  = mk(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0);
        tbl[1]  = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        32'h4);
        tbl[2]  = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'h4,        32'h8);
        tbl[3]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h8,        32'hC);
        tbl[4]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h8,        32'h10);
        tbl[5]  = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'h8,        32'h10);
        tbl[6]  = mk(1'b0, 1'b1, 32'h14,       1'b1, 32'hC,        32'h14);
        tbl[7]  = mk(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h14);
        tbl[8]  = mk(1'b1, 1'b1, 32'h1C,       1'b1, 32'h14,       32'h18);
        tbl[9]  = mk(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h1C);
        tbl[10] = mk(1'b1, 1'b1, 32'h33,       1'b1, 32'h1C,       32'h20);
        tbl[11] = mk(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h30);
        tbl[12] = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'h30,       32'h34);
        tbl[13] = mk(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h34,      32'h38);
        tbl[14] = mk(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'hFFFF_FFFC);
        tbl[15] = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, 32'h0);
        tbl[16] = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        32'h4);

`ifdef FETCH_FAULT_EN
        // Misaligned and top-of-space targets fault in this build.
        n_main = 10;
`else
        n_main = 17;
`endif

        // Reset state.
        tick();
        tick();
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset rom_addr", rom_addr, 32'h0);
        chk("reset out_instr", out_instr, 32'h0);
        chk("reset out_pc", out_pc, 32'h0);
        chk("reset out_pc_plus4", out_pc_plus4, 32'h0);
        chk("reset fetch_fault", {31'd0, fetch_fault}, 32'd0);
        reset_n = 1'b1;

        // Vector table: check the current outputs, then apply inputs for the next edge.
        for (int i = 0; i < n_main; i++) begin
            chk($sformatf("v%0d out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].e_valid});
            chk($sformatf("v%0d rom_addr", i), rom_addr, tbl[i].e_addr);
            chk($sformatf("v%0d fetch_fault", i), {31'd0, fetch_fault}, 32'd0);
            if (tbl[i].e_valid) begin
                chk_head($sformatf("v%0d", i), tbl[i].e_pc);
            end
            $display("vec %0d: valid=%0b pc=%h instr=%h addr=%h | rdy=%0b redir=%0b tgt=%h",
                     i, out_valid, out_pc, out_instr, rom_addr,
                     tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
            out_ready      = tbl[i].rdy;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            tick();
        end
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;

        // Asynchronous reset mid-stream: outputs clear before any clock edge.
        chk("pre-reset out_valid", {31'd0, out_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("async reset rom_addr", rom_addr, 32'h0);
        chk("async reset out_pc_plus4", out_pc_plus4, 32'h0);
        $display("async reset: valid=%0b addr=%h", out_valid, rom_addr);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        chk("restart idle out_valid", {31'd0, out_valid}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_head($sformatf("restart%0d", k), 32'(k * 4));
            $display("restart %0d: pc=%h instr=%h", k, out_pc, out_instr);
        end

`ifdef FETCH_FAULT_EN
        // Redirect to word 62, one past the populated ROM.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hF8;
        tick();
        redirect_valid = 1'b0;
        chk("f1 out_valid", {31'd0, out_valid}, 32'd0);
        chk("f1 rom_addr", rom_addr, 32'hF8);
        tick();
        chk("f2 fetch_fault", {31'd0, fetch_fault}, 32'd1);
        chk("f2 out_valid", {31'd0, out_valid}, 32'd0);
        chk("f2 rom_addr", rom_addr, 32'hF8);
        tick();
        chk("f3 fetch_fault", {31'd0, fetch_fault}, 32'd1);
        chk("f3 rom_addr", rom_addr, 32'hF8);
        $display("fault: ff=%0b addr=%h", fetch_fault, rom_addr);
        // Recover with a redirect to 0.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        tick();
        redirect_valid = 1'b0;
        chk("f4 fetch_fault", {31'd0, fetch_fault}, 32'd0);
        chk("f4 out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk_head("f5", 32'h0);
        // Misaligned target faults again.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h6;
        tick();
        redirect_valid = 1'b0;
        chk("f6 rom_addr", rom_addr, 32'h6);
        tick();
        chk("f7 fetch_fault", {31'd0, fetch_fault}, 32'd1);
        chk("f7 rom_addr", rom_addr, 32'h6);
        $display("refault: ff=%0b addr=%h", fetch_fault, rom_addr);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
